// File: rtl/stat_pkt_meter_pkg.sv
// Shared types for the ingress packet meter and its descriptor FIFO.
// PktDesc is also the layout consumed by the stats write controller.
package stat_pkt_meter_pkg;

  localparam int A_W            = 10;
  localparam int D_W            = 32;
  localparam int BYTES_PER_BEAT = D_W / 8;

  typedef enum logic {
    IDLE_METER = 1'b0,
    IN_PKT     = 1'b1
  } states_meter;

  typedef struct packed {
    logic [A_W-1:0] flow;
    logic [15:0]    size;
  } PktDesc;

  localparam int DESC_W = $bits(PktDesc);

endpackage

// File: rtl/stat_desc_fifo.sv
// Show-ahead descriptor FIFO. The head entry sits in a register, so it only
// moves when the queue advances and holds its last value while empty.
module stat_desc_fifo
  import stat_pkt_meter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [DESC_W-1:0]        push_data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     empty_o,
  output logic [DESC_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  PktDesc             mem_q [DEPTH];
  PktDesc             head_q;
  PktDesc             push_desc;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   rd_next;
  logic [LVL_W-1:0]   level_q;
  logic               do_push;
  logic               do_pop;

  assign push_desc = PktDesc'(push_data_i);
  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_pop    = pop_i & ~empty_o;
  // A push into a full queue only lands if the head leaves on the same edge.
  assign do_push   = push_i & (~full_o | do_pop);
  assign rd_next   = rd_ptr_q + 1'b1;
  assign head_o    = head_q;
  assign level_o   = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_desc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_next;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
      // Head follows either the incoming entry (queue empty after this edge
      // otherwise) or the next stored entry.
      if (do_push && (empty_o || (do_pop && level_q == LVL_W'(1)))) begin
        head_q <= push_desc;
      end else if (do_pop && level_q > LVL_W'(1)) begin
        head_q <= mem_q[rd_next];
      end
    end
  end

endmodule

// File: rtl/stat_pkt_meter.sv
// Ingress packet meter: measures each packet's byte length from sop/eop beats
// and queues a (flow, size) descriptor for the stats write controller.
module stat_pkt_meter
  import stat_pkt_meter_pkg::*;
#(
  parameter int A_WIDTH    = A_W,
  parameter int D_WIDTH    = D_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          pkt_valid_i,
  input  logic                          pkt_sop_i,
  input  logic                          pkt_eop_i,
  input  logic [1:0]                    pkt_mod_i,
  input  logic [A_WIDTH-1:0]            pkt_flow_i,
  output logic                          desc_valid_o,
  input  logic                          desc_ready_i,
  output logic [A_WIDTH-1:0]            desc_flow_o,
  output logic [15:0]                   desc_size_o,
  output logic [CNT_W-1:0]              drop_cnt_o,
  output logic [CNT_W-1:0]              err_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam logic [16:0] BEAT_BYTES = 17'(D_WIDTH / 8);

  function automatic logic [15:0] sat_size(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  states_meter        state_q, state_d;
  logic [A_WIDTH-1:0] flow_q, flow_d;
  logic [16:0]        acc_q, acc_d;
  logic [16:0]        last_bytes;
  logic               push;
  logic               err;
  logic               drop;
  PktDesc             push_desc;
  PktDesc             head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;

  assign last_bytes = (pkt_mod_i == 2'd0) ? BEAT_BYTES : 17'(pkt_mod_i);

  always_comb begin
    state_d   = state_q;
    flow_d    = flow_q;
    acc_d     = acc_q;
    push      = 1'b0;
    err       = 1'b0;
    push_desc = '0;
    if (pkt_valid_i) begin
      if (pkt_sop_i) begin
        // A sop while a packet is open abandons the partial packet.
        err = (state_q == IN_PKT);
        if (pkt_eop_i) begin
          push           = 1'b1;
          push_desc.flow = pkt_flow_i;
          push_desc.size = sat_size(last_bytes, 17'd0);
          state_d        = IDLE_METER;
        end else begin
          flow_d  = pkt_flow_i;
          acc_d   = BEAT_BYTES;
          state_d = IN_PKT;
        end
      end else if (state_q == IDLE_METER) begin
        err = 1'b1;
      end else if (pkt_eop_i) begin
        push           = 1'b1;
        push_desc.flow = flow_q;
        push_desc.size = sat_size(acc_q, last_bytes);
        state_d        = IDLE_METER;
      end else begin
        acc_d = {1'b0, sat_size(acc_q, BEAT_BYTES)};
      end
    end
  end

  assign drop = push & fifo_full & ~(desc_valid_o & desc_ready_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE_METER;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (err)  err_cnt_q  <= sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    flow_q <= flow_d;
    acc_q  <= acc_d;
  end

  stat_desc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_data_i (push_desc),
    .full_o      (fifo_full),
    .pop_i       (desc_ready_i),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .level_o     (fifo_level_o)
  );

  assign desc_valid_o = ~fifo_empty;
  assign desc_flow_o  = head.flow;
  assign desc_size_o  = head.size;
  assign drop_cnt_o   = drop_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_stat_pkt_meter.sv
// Scoreboard bench for stat_pkt_meter: expected descriptors are queued when a
// packet is driven and compared as the DUT hands them over.
module tb_stat_pkt_meter;

  localparam int AW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_valid, pkt_sop, pkt_eop;
  logic [1:0]    pkt_mod;
  logic [AW-1:0] pkt_flow;
  logic          desc_valid, desc_ready;
  logic [AW-1:0] desc_flow;
  logic [15:0]   desc_size;
  logic [CW-1:0] drop_cnt, err_cnt;
  logic [3:0]    fifo_level;

  int nvec = 0;
  int nerr = 0;
  logic [AW+15:0] exp_q[$];

  always #5 clk = ~clk;

  stat_pkt_meter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .pkt_valid_i  (pkt_valid),
    .pkt_sop_i    (pkt_sop),
    .pkt_eop_i    (pkt_eop),
    .pkt_mod_i    (pkt_mod),
    .pkt_flow_i   (pkt_flow),
    .desc_valid_o (desc_valid),
    .desc_ready_i (desc_ready),
    .desc_flow_o  (desc_flow),
    .desc_size_o  (desc_size),
    .drop_cnt_o   (drop_cnt),
    .err_cnt_o    (err_cnt),
    .fifo_level_o (fifo_level)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs only change 1ns after a rising edge, so ready/valid seen here are
  // the values the DUT sees at the following edge.
  always @(negedge clk) begin
    logic [AW+15:0] e;
    if (rst_n && desc_valid && desc_ready) begin
      check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("desc_flow", 32'(desc_flow), 32'(e[AW+15:16]));
        check_val("desc_size", 32'(desc_size), 32'(e[15:0]));
      end
    end
  end

  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [1:0] m, input logic [AW-1:0] f);
    pkt_valid = v; pkt_sop = s; pkt_eop = e; pkt_mod = m; pkt_flow = f;
    @(posedge clk);
    #1;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
  endtask

  task automatic pkt(input logic [AW-1:0] f, input int beats, input logic [1:0] m, input bit keep);
    int sz;
    sz = (beats - 1) * 4 + ((m == 2'd0) ? 4 : int'(m));
    if (sz > 65535) sz = 65535;
    if (keep) exp_q.push_back({f, 16'(sz)});
    if (beats == 1) begin
      beat(1'b1, 1'b1, 1'b1, m, f);
    end else begin
      beat(1'b1, 1'b1, 1'b0, 2'($urandom), f);
      beat(1'b0, 1'b1, 1'b1, 2'($urandom), AW'($urandom));
      for (int i = 0; i < beats - 2; i++) beat(1'b1, 1'b0, 1'b0, 2'($urandom), AW'($urandom));
      beat(1'b1, 1'b0, 1'b1, m, AW'($urandom));
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; desc_ready = 1'b0;
    pkt_valid = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_mod = '0; pkt_flow = '0;
    #12;
    check_val("rst_valid", 32'(desc_valid), 32'd0);
    check_val("rst_level", 32'(fifo_level), 32'd0);
    check_val("rst_err",   32'(err_cnt), 32'd0);
    check_val("rst_drop",  32'(drop_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // single-beat packet
    pkt(10'd5, 1, 2'd3, 1'b1);
    check_val("sb_valid", 32'(desc_valid), 32'd1);
    check_val("sb_flow",  32'(desc_flow), 32'd5);
    check_val("sb_size",  32'(desc_size), 32'd3);
    check_val("sb_level", 32'(fifo_level), 32'd1);
    desc_ready = 1'b1;
    @(posedge clk); #1;
    check_val("sb_popped", 32'(desc_valid), 32'd0);
    check_val("sb_hold",   32'(desc_size), 32'd3);

    // multi-beat packets, drained in order
    pkt(10'h3FF, 4, 2'd0, 1'b1);
    pkt(10'h012, 3, 2'd1, 1'b1);
    wait_drain("multi_drain");
    check_val("multi_err", 32'(err_cnt), 32'd0);

    // framing errors
    beat(1'b1, 1'b0, 1'b1, 2'd0, 10'd0);
    check_val("err_eop_nosop", 32'(err_cnt), 32'd1);
    check_val("err_no_desc",   32'(desc_valid), 32'd0);
    beat(1'b1, 1'b1, 1'b0, 2'd0, 10'd7);
    beat(1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
    exp_q.push_back({10'd8, 16'd2});
    beat(1'b1, 1'b1, 1'b1, 2'd2, 10'd8);
    check_val("err_missing_eop", 32'(err_cnt), 32'd2);
    wait_drain("err_drain");

    // backpressure: 10 packets into an 8-deep queue
    desc_ready = 1'b0;
    for (int i = 0; i < 10; i++) pkt(AW'(20 + i), 1, 2'(i), i < 8);
    check_val("bp_level", 32'(fifo_level), 32'd8);
    check_val("bp_drop",  32'(drop_cnt), 32'd2);
    check_val("bp_head",  32'(desc_flow), 32'd20);
    desc_ready = 1'b1;
    wait_drain("bp_drain");
    check_val("bp_empty", 32'(fifo_level), 32'd0);

    // full with simultaneous push and pop
    desc_ready = 1'b0;
    for (int i = 0; i < 8; i++) pkt(AW'(40 + i), 1, 2'd1, 1'b1);
    check_val("full_level", 32'(fifo_level), 32'd8);
    desc_ready = 1'b1;
    pkt(10'd60, 1, 2'd2, 1'b1);
    check_val("full_pushpop_level", 32'(fifo_level), 32'd8);
    check_val("full_pushpop_drop",  32'(drop_cnt), 32'd2);
    wait_drain("full_drain");

    // size saturation
    pkt(10'h2AA, 16385, 2'd0, 1'b1);
    wait_drain("sat_drain");
    check_val("sat_err", 32'(err_cnt), 32'd2);

    // asynchronous reset mid-packet with a descriptor queued
    desc_ready = 1'b0;
    pkt(10'd3, 1, 2'd1, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 2'd0, 10'd9);
    beat(1'b1, 1'b0, 1'b0, 2'd0, 10'd0);
    #3 rst_n = 1'b0;
    #2;
    check_val("arst_valid", 32'(desc_valid), 32'd0);
    check_val("arst_flow",  32'(desc_flow), 32'd0);
    check_val("arst_size",  32'(desc_size), 32'd0);
    check_val("arst_drop",  32'(drop_cnt), 32'd0);
    check_val("arst_err",   32'(err_cnt), 32'd0);
    check_val("arst_level", 32'(fifo_level), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    desc_ready = 1'b1;
    beat(1'b1, 1'b0, 1'b1, 2'd0, 10'd9);
    check_val("post_rst_discard", 32'(err_cnt), 32'd1);
    check_val("post_rst_novalid", 32'(desc_valid), 32'd0);
    pkt(10'h15, 2, 2'd3, 1'b1);
    wait_drain("post_rst_drain");
    check_val("post_rst_err", 32'(err_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
